lector_sensor_temp: RTL and testbench

//  Master-side serial reader for the digital temperature sensor. Periodically clocks a
//  16-bit frame out of the sensor and converts its 0.0625 C/LSB code to signed tenths of C.

---
 rtl/temp_pkg.sv | 26 ++
 rtl/conv_temp_decimas.sv | 24 ++
 rtl/lector_sensor_temp.sv | 133 +++++++++++++
 tb/tb_lector_sensor_temp.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/temp_pkg.sv
// Shared types and constants for the temperature acquisition path.
package temp_pkg;

  localparam int TEMP_W = 11;
  typedef logic signed [TEMP_W-1:0] temp_t;

  localparam int TEMP_MAX = 1023;
  localparam int TEMP_MIN = -1024;

  // Low 3 bits of every good sensor frame
  localparam logic [2:0] MARCA_SENSOR = 3'b111;

  // Range comparator thresholds, tenths of C
  localparam int TEMP_BAJO = 180;
  localparam int TEMP_ALTO = 259;

  typedef enum logic [2:0] {
    REPOSO,
    ESPERA,
    CS_INI,
    DESPLAZA,
    CS_FIN,
    CONVIERTE
  } estado_t;

endpackage

// File: rtl/conv_temp_decimas.sv
// 13-bit sensor code (0.0625 C/LSB) -> signed tenths of C, rounded and saturated.
module conv_temp_decimas
  import temp_pkg::*;
(
  input  logic [12:0]              codigo,
  output logic signed [TEMP_W-1:0] temp
);

  localparam logic signed [16:0] LIM_ALTO = 17'(TEMP_MAX);
  localparam logic signed [16:0] LIM_BAJO = 17'(TEMP_MIN);

  logic signed [16:0] ext, prod, redo;

  // x10 via shifts, +8 then >>>4 rounds half toward +inf, then clamp to 11 bits
  always_comb begin
    ext  = {{4{codigo[12]}}, codigo};
    prod = (ext <<< 3) + (ext <<< 1);
    redo = (prod + 17'sd8) >>> 4;
    temp = redo[TEMP_W-1:0];
    if (redo > LIM_ALTO)      temp = temp_t'(TEMP_MAX);
    else if (redo < LIM_BAJO) temp = temp_t'(TEMP_MIN);
  end

endmodule

// File: rtl/lector_sensor_temp.sv
// Periodic serial reader for the temperature sensor: frames a 16-bit mode-0 read,
// checks the frame marker and publishes the converted sample with a valid pulse.
module lector_sensor_temp
  import temp_pkg::*;
#(
  parameter int DIV_SCLK        = 4,
  parameter int N_BITS          = 16,
  parameter int PERIODO_MUESTRA = 100000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     habilitar,
  input  logic                     sensor_miso,
  output logic                     sensor_sclk,
  output logic                     sensor_cs_n,
  output logic signed [TEMP_W-1:0] temp_salida,
  output logic                     temp_valida,
  output logic                     error_sensor
);

  localparam int DIV_W = $clog2(DIV_SCLK);
  localparam int BIT_W = $clog2(N_BITS);
  localparam int PER_W = $clog2(PERIODO_MUESTRA);

  estado_t           estado, estado_n;
  logic [DIV_W-1:0]  div_cnt, div_n;
  logic              alta, alta_n;     // current sclk half is the high one
  logic [BIT_W-1:0]  bit_cnt, bit_n;
  logic [PER_W-1:0]  per_cnt;          // cycles since last CS_INI entry
  logic [N_BITS-1:0] raw;
  logic              fin_div, muestra, marca_ok;
  temp_t             temp_conv;

  assign fin_div  = (div_cnt == DIV_W'(DIV_SCLK - 1));
  assign muestra  = (estado_n == DESPLAZA) && alta_n && !((estado == DESPLAZA) && alta);
  assign marca_ok = (raw[2:0] == MARCA_SENSOR);

  conv_temp_decimas u_conv (
    .codigo (raw[N_BITS-1:3]),
    .temp   (temp_conv)
  );

  // Next state and sub-counters of the frame sequencer
  always_comb begin
    estado_n = estado;
    div_n    = div_cnt;
    alta_n   = alta;
    bit_n    = bit_cnt;
    case (estado)
      REPOSO: if (habilitar) begin
        estado_n = CS_INI;
        div_n    = '0;
      end
      ESPERA: begin
        if (!habilitar) estado_n = REPOSO;
        else if (per_cnt == PER_W'(PERIODO_MUESTRA - 1)) begin
          estado_n = CS_INI;
          div_n    = '0;
        end
      end
      CS_INI: begin
        if (fin_div) begin
          estado_n = DESPLAZA;
          div_n    = '0;
          alta_n   = 1'b0;
          bit_n    = '0;
        end else div_n = div_cnt + 1'b1;
      end
      DESPLAZA: begin
        if (fin_div) begin
          div_n = '0;
          if (!alta) alta_n = 1'b1;
          else begin
            alta_n = 1'b0;
            if (bit_cnt == BIT_W'(N_BITS - 1)) estado_n = CS_FIN;
            else bit_n = bit_cnt + 1'b1;
          end
        end else div_n = div_cnt + 1'b1;
      end
      CS_FIN: begin
        if (fin_div) begin
          estado_n = CONVIERTE;
          div_n    = '0;
        end else div_n = div_cnt + 1'b1;
      end
      CONVIERTE: estado_n = habilitar ? ESPERA : REPOSO;
      default:   estado_n = REPOSO;
    endcase
  end

  // Sequencer registers; sclk/cs_n registered from the next state so they never glitch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado      <= REPOSO;
      div_cnt     <= '0;
      alta        <= 1'b0;
      bit_cnt     <= '0;
      sensor_cs_n <= 1'b1;
      sensor_sclk <= 1'b0;
      raw         <= '0;
    end else begin
      estado      <= estado_n;
      div_cnt     <= div_n;
      alta        <= alta_n;
      bit_cnt     <= bit_n;
      sensor_cs_n <= !(estado_n inside {CS_INI, DESPLAZA, CS_FIN});
      sensor_sclk <= (estado_n == DESPLAZA) && alta_n;
      if (muestra) raw <= {raw[N_BITS-2:0], sensor_miso};
    end
  end

  // Period counter restarts at each CS_INI entry so frame starts are exactly one period apart
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        per_cnt <= '0;
    else if ((estado_n == CS_INI) && (estado != CS_INI)) per_cnt <= '0;
    else if (estado == REPOSO)                         per_cnt <= '0;
    else                                               per_cnt <= per_cnt + 1'b1;
  end

  // Result publication: a bad marker raises error and keeps the previous sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      temp_salida  <= '0;
      temp_valida  <= 1'b0;
      error_sensor <= 1'b0;
    end else begin
      temp_valida  <= (estado == CONVIERTE) && marca_ok;
      error_sensor <= (estado == CONVIERTE) && !marca_ok;
      if ((estado == CONVIERTE) && marca_ok) temp_salida <= temp_conv;
    end
  end

endmodule

// File: tb/tb_lector_sensor_temp.sv
// Bench for lector_sensor_temp: behavioural sensor, bus monitor, arithmetic reference model.
module tb_lector_sensor_temp;
  import temp_pkg::*;

  localparam int D     = 3;
  localparam int NB    = 16;
  localparam int P     = 200;
  localparam int LARGO = D * (2 * NB + 2) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic habilitar = 1'b0;
  logic sensor_miso = 1'b0;
  logic sensor_sclk, sensor_cs_n, temp_valida, error_sensor;
  logic signed [10:0] temp_salida;

  always #5 clk = ~clk;

  lector_sensor_temp #(.DIV_SCLK(D), .N_BITS(NB), .PERIODO_MUESTRA(P)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .habilitar    (habilitar),
    .sensor_miso  (sensor_miso),
    .sensor_sclk  (sensor_sclk),
    .sensor_cs_n  (sensor_cs_n),
    .temp_salida  (temp_salida),
    .temp_valida  (temp_valida),
    .error_sensor (error_sensor)
  );

  typedef struct {int cyc; int rise; bit val; bit err; int temp;} res_t;

  int tests = 0, fails = 0, cyc = 0;
  int last_temp = 0;
  res_t res_q[$];
  int cs_fall_q[$], rises_q[$];
  logic [15:0] pend_q[$], sent_q[$];
  int rise_cnt = 0, last_rise = 0, hi_run = 0, bad_sclk = 0;
  logic prev_cs = 1'b1, prev_sclk = 1'b0;
  logic [15:0] cur = '0;
  int idx = 0;

  // Reference: tenths = round-half-up(t * 0.625), clamped to 11-bit signed
  function automatic int modelo(int t);
    int n, d;
    n = t * 10 + 8;
    d = (n >= 0) ? n / 16 : -((-n + 15) / 16);
    if (d > 1023) d = 1023;
    if (d < -1024) d = -1024;
    return d;
  endfunction

  function automatic int code_of(logic [15:0] f);
    int t;
    t = int'(f[15:3]);
    if (f[15]) t -= 8192;
    return t;
  endfunction

  function automatic logic [15:0] frame_of(int t, logic [2:0] m);
    logic [12:0] c;
    c = t[12:0];
    return {c, m};
  endfunction

  function automatic int rnd_code();
    int t;
    t = $urandom_range(0, 8191);
    if (t >= 4096) t -= 8192;
    return t;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Sensor: first bit out on cs_n fall, next bit on each sclk fall
  always @(negedge sensor_cs_n) begin
    if (pend_q.size() > 0) cur = pend_q.pop_front();
    else cur = frame_of(rnd_code(), 3'b111);
    sent_q.push_back(cur);
    idx = 15;
    sensor_miso = cur[15];
  end

  always @(negedge sensor_sclk) begin
    if (sensor_cs_n === 1'b0) begin
      idx--;
      if (idx >= 0) sensor_miso = cur[idx];
    end
  end

  // Monitor: bus timing records and result pulses
  always @(negedge clk) begin
    if (prev_cs === 1'b1 && sensor_cs_n === 1'b0) begin
      cs_fall_q.push_back(cyc);
      rise_cnt = 0;
    end
    if (prev_cs === 1'b0 && sensor_cs_n === 1'b1) begin
      rises_q.push_back(rise_cnt);
      last_rise = cyc;
    end
    if (prev_sclk === 1'b0 && sensor_sclk === 1'b1) rise_cnt++;
    if (sensor_sclk === 1'b1) begin
      hi_run++;
      if (sensor_cs_n !== 1'b0) bad_sclk++;
    end else begin
      if (prev_sclk === 1'b1 && hi_run != D) bad_sclk++;
      hi_run = 0;
    end
    if (temp_valida === 1'b1 || error_sensor === 1'b1) begin
      res_t r;
      r.cyc = cyc; r.rise = last_rise; r.val = temp_valida; r.err = error_sensor;
      r.temp = int'(temp_salida);
      res_q.push_back(r);
    end
    prev_cs   = sensor_cs_n;
    prev_sclk = sensor_sclk;
  end

  task automatic wait_res(input int budget, output bit to, output res_t r);
    to = 1'b1;
    r = '{default: 0};
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (res_q.size() > 0) begin
        r = res_q.pop_front();
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic go_idle();
    @(negedge clk) habilitar = 1'b0;
    repeat (LARGO + 5) @(posedge clk);
    res_q.delete(); sent_q.delete(); cs_fall_q.delete(); rises_q.delete(); pend_q.delete();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (sensor_cs_n !== 1'b1) begin fails++; $display("FAIL reset_cs_n: got %b want 1", sensor_cs_n); end
    tests++; if (sensor_sclk !== 1'b0) begin fails++; $display("FAIL reset_sclk: got %b want 0", sensor_sclk); end
    tests++; if (temp_salida !== 11'sd0) begin fails++; $display("FAIL reset_temp: got %0d want 0", temp_salida); end
    tests++; if (temp_valida !== 1'b0) begin fails++; $display("FAIL reset_valida: got %b want 0", temp_valida); end
    tests++; if (error_sensor !== 1'b0) begin fails++; $display("FAIL reset_error: got %b want 0", error_sensor); end
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_single_frame();
    bit to; res_t r; int rs;
    pend_q.push_back(16'h0C87);
    @(negedge clk) habilitar = 1'b1;
    wait_res(2 * LARGO, to, r);
    rs = (rises_q.size() > 0) ? rises_q[0] : -1;
    tests++; if (to) begin fails++; $display("FAIL single_timeout: got none want pulse"); end
    tests++; if (r.val !== 1'b1 || r.err !== 1'b0) begin fails++; $display("FAIL single_kind: got val=%b err=%b want 1/0", r.val, r.err); end
    tests++; if (r.temp != 250) begin fails++; $display("FAIL single_temp: got %0d want 250", r.temp); end
    tests++; if (r.cyc != r.rise + 1) begin fails++; $display("FAIL single_latency: got %0d want %0d", r.cyc, r.rise + 1); end
    tests++; if (rs != 16) begin fails++; $display("FAIL single_sclk_rises: got %0d want 16", rs); end
    tests++; if (bad_sclk != 0) begin fails++; $display("FAIL single_sclk_timing: got %0d bad want 0", bad_sclk); end
    last_temp = 250;
    go_idle();
  endtask

  task automatic test_codes();
    int fijos[5] = '{288, 414, 415, -1, 1};
    int want[5]  = '{TEMP_BAJO, TEMP_ALTO, TEMP_ALTO, -1, 1};
    int codes[11];
    bit to; res_t r; int exp;
    for (int i = 0; i < 11; i++) begin
      codes[i] = (i < 5) ? fijos[i] : rnd_code();
      pend_q.push_back(frame_of(codes[i], 3'b111));
    end
    @(negedge clk) habilitar = 1'b1;
    for (int i = 0; i < 11; i++) begin
      wait_res(P + LARGO, to, r);
      exp = (i < 5) ? want[i] : modelo(codes[i]);
      tests++; if (to || r.val !== 1'b1) begin fails++; $display("FAIL codes_valid[%0d]: got val=%b timeout=%b want valid", i, r.val, to); end
      tests++; if (r.temp != exp) begin fails++; $display("FAIL codes_temp t=%0d: got %0d want %0d", codes[i], r.temp, exp); end
      last_temp = exp;
    end
    go_idle();
  endtask

  task automatic test_saturation();
    int codes[6] = '{4095, -4096, 1638, 1637, -1639, -1640};
    int want[6]  = '{1023, -1024, 0, 0, 0, 0};
    bit to; res_t r; int exp;
    foreach (codes[i]) pend_q.push_back(frame_of(codes[i], 3'b111));
    @(negedge clk) habilitar = 1'b1;
    foreach (codes[i]) begin
      wait_res(P + LARGO, to, r);
      exp = (i < 2) ? want[i] : modelo(codes[i]);
      tests++; if (to || r.temp != exp) begin fails++; $display("FAIL sat_temp t=%0d: got %0d want %0d (timeout=%b)", codes[i], r.temp, exp, to); end
      last_temp = exp;
    end
    go_idle();
  endtask

  task automatic test_bad_marker();
    bit to; res_t r; int exp;
    pend_q.push_back(16'h0C80);
    for (int i = 0; i < 3; i++) begin
      logic [2:0] m;
      m = 3'($urandom_range(0, 6));
      pend_q.push_back(frame_of(rnd_code(), m));
    end
    exp = last_temp;
    @(negedge clk) habilitar = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_res(P + LARGO, to, r);
      tests++; if (to || r.err !== 1'b1 || r.val !== 1'b0) begin fails++; $display("FAIL marker_kind[%0d]: got err=%b val=%b timeout=%b want 1/0", i, r.err, r.val, to); end
      tests++; if (r.temp != exp) begin fails++; $display("FAIL marker_hold[%0d]: got %0d want %0d", i, r.temp, exp); end
      repeat (2) @(posedge clk);
      tests++; if (res_q.size() != 0) begin fails++; $display("FAIL marker_pulse_width[%0d]: got %0d extra want 0", i, res_q.size()); end
    end
    go_idle();
  endtask

  task automatic test_period();
    bit to; res_t r; logic [15:0] f; int nf, exp;
    bad_sclk = 0;
    @(negedge clk) habilitar = 1'b1;
    for (int i = 0; i < 5 * P && cs_fall_q.size() < 4; i++) @(posedge clk);
    tests++; if (cs_fall_q.size() < 4) begin fails++; $display("FAIL period_frames: got %0d want 4", cs_fall_q.size()); end
    for (int k = 1; k < 4 && k < cs_fall_q.size(); k++) begin
      tests++; if (cs_fall_q[k] - cs_fall_q[k-1] != P) begin fails++; $display("FAIL period_gap[%0d]: got %0d want %0d", k, cs_fall_q[k] - cs_fall_q[k-1], P); end
    end
    for (int k = 0; k < 3 && k < rises_q.size(); k++) begin
      tests++; if (rises_q[k] != 16) begin fails++; $display("FAIL period_rises[%0d]: got %0d want 16", k, rises_q[k]); end
    end
    tests++; if (bad_sclk != 0) begin fails++; $display("FAIL period_sclk_timing: got %0d bad want 0", bad_sclk); end
    for (int i = 0; i < LARGO && rise_cnt < 5; i++) @(posedge clk);
    @(negedge clk) habilitar = 1'b0;
    f = sent_q[$];
    res_q.delete();
    wait_res(2 * LARGO, to, r);
    exp = modelo(code_of(f));
    tests++; if (to || r.val !== 1'b1 || r.temp != exp) begin fails++; $display("FAIL drop_frame: got val=%b temp=%0d want 1/%0d (timeout=%b)", r.val, r.temp, exp, to); end
    last_temp = exp;
    nf = cs_fall_q.size();
    repeat (2 * P) @(posedge clk);
    tests++; if (cs_fall_q.size() != nf || sensor_cs_n !== 1'b1) begin fails++; $display("FAIL drop_idle: got %0d new frames cs_n=%b want 0/1", cs_fall_q.size() - nf, sensor_cs_n); end
    go_idle();
  endtask

  task automatic test_reset_mid();
    bit to; res_t r; logic [15:0] f; int exp, rs;
    pend_q.push_back(16'h0C87);
    @(negedge clk) habilitar = 1'b1;
    for (int i = 0; i < LARGO && rise_cnt < 6; i++) @(posedge clk);
    @(posedge clk) #1 rst_n = 1'b0;
    #1;
    tests++; if (sensor_cs_n !== 1'b1) begin fails++; $display("FAIL midrst_cs_n: got %b want 1", sensor_cs_n); end
    tests++; if (sensor_sclk !== 1'b0) begin fails++; $display("FAIL midrst_sclk: got %b want 0", sensor_sclk); end
    tests++; if (temp_salida !== 11'sd0 || temp_valida !== 1'b0 || error_sensor !== 1'b0) begin fails++; $display("FAIL midrst_outputs: got temp=%0d val=%b err=%b want 0/0/0", temp_salida, temp_valida, error_sensor); end
    @(negedge clk); #1;
    res_q.delete(); sent_q.delete(); rises_q.delete(); pend_q.delete(); bad_sclk = 0;
    f = frame_of(rnd_code(), 3'b111);
    pend_q.push_back(f);
    @(negedge clk) rst_n = 1'b1;
    wait_res(2 * LARGO, to, r);
    exp = modelo(code_of(f));
    rs = (rises_q.size() > 0) ? rises_q[0] : -1;
    tests++; if (to || r.val !== 1'b1 || r.temp != exp) begin fails++; $display("FAIL midrst_frame: got val=%b temp=%0d want 1/%0d (timeout=%b)", r.val, r.temp, exp, to); end
    tests++; if (rs != 16 || bad_sclk != 0) begin fails++; $display("FAIL midrst_bus: got rises=%0d bad=%0d want 16/0", rs, bad_sclk); end
    tests++; if (r.cyc != r.rise + 1) begin fails++; $display("FAIL midrst_latency: got %0d want %0d", r.cyc, r.rise + 1); end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_codes();
    test_saturation();
    test_bad_marker();
    test_period();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
